// File: rtl/seq_control_unit.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout, resumable HALT and sticky FAULT.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module seq_control_unit #(
  parameter int OPC_W       = 4,
  parameter int FLAG_W      = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FLAG_W-1:0] status_reg,
  input  logic              mem_ack,
  input  logic              resume,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ir_load_en,
  output logic              reg_write_en,
  output logic              alu_en,
  output logic [3:0]        alu_opcode,
  output logic              jump_en,
  output logic              halt,
  output logic              fault,
  output logic [CNT_W-1:0]  perf_instr
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT
  } state_t;

  state_t           state;
  logic [OPC_W-1:0] op_q;
  logic [TW-1:0]    wait_cnt;
  logic [3:0]       op4;
  logic             op_alu_wb;
  logic             op_cmp;
  logic             op_mem;
  logic             timeout_hit;
  logic             unused_flags;

  assign op4          = op_q[3:0];
  assign op_alu_wb    = (op4 inside {4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hD});
  assign op_cmp       = (op4 == 4'hC);
  assign op_mem       = (op4 == 4'h1) || (op4 == 4'h2);
  assign unused_flags = ^status_reg;

  // The ack in the limit cycle takes priority, so the fault needs a missing ack too.
  assign timeout_hit  = (MEM_TIMEOUT != 0) && !mem_ack && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        IDLE:   state <= FETCH;
        FETCH: begin
          if (mem_ack)          state <= DECODE;
          else if (timeout_hit) state <= FAULT;
          else                  wait_cnt <= wait_cnt + TW'(1);
        end
        DECODE: begin
          op_q <= opcode;
          if (((opcode >> 4) != '0) || (opcode[3:0] == 4'hE)) state <= FAULT;
          else if (opcode[3:0] == 4'hF)                        state <= HALT;
          else                                                 state <= EXEC;
        end
        EXEC: begin
          if (op_alu_wb)   state <= WB;
          else if (op_mem) state <= MEM;
          else             state <= FETCH;
        end
        MEM: begin
          if (mem_ack)          state <= (op4 == 4'h1) ? WB : FETCH;
          else if (timeout_hit) state <= FAULT;
          else                  wait_cnt <= wait_cnt + TW'(1);
        end
        WB:      state <= FETCH;
        HALT:    if (resume) state <= HALT == HALT ? FETCH : HALT;
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_load_en   = 1'b0;
    reg_write_en = 1'b0;
    alu_en       = 1'b0;
    alu_opcode   = 4'h0;
    jump_en      = 1'b0;
    halt         = 1'b0;
    fault        = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        ir_load_en = mem_ack;
      end
      EXEC: begin
        if (op_alu_wb || op_cmp) begin
          alu_en     = 1'b1;
          alu_opcode = op4;
        end
        case (op4)
          4'h8:    jump_en = 1'b1;
          4'h9:    jump_en = status_reg[0];
          4'hA:    jump_en = status_reg[1];
          4'hB:    jump_en = status_reg[2];
          default: jump_en = 1'b0;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op4 == 4'h2);
      end
      WB:    reg_write_en = 1'b1;
      HALT:  halt = 1'b1;
      FAULT: begin
        halt  = 1'b1;
        fault = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] perf_q;

  // HLT leaves through HALT, so it never reaches any of these exits and never retires.
  assign retire = ((state == EXEC) && !op_alu_wb && !op_mem) ||
                  ((state == MEM) && mem_ack && (op4 == 4'h2)) ||
                  (state == WB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      perf_q <= '0;
    else if (retire) perf_q <= perf_q + CNT_W'(1);
  end

  assign perf_instr = perf_q;
`else
  assign perf_instr = '0;
`endif

endmodule

// File: tb/tb_seq_control_unit.sv
// Randomized bench for seq_control_unit: expected strobes per cycle come from the instruction phase/latency rules.
// Perf counter expectations follow PERF_CNT_EN when defined for the build.
module tb_seq_control_unit;
  localparam int OPC_W = 4, FLAG_W = 4, MEM_TIMEOUT = 15, CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [OPC_W-1:0]  opcode;
  logic [FLAG_W-1:0] status_reg;
  logic              mem_ack, resume;
  logic              mem_req, mem_we, ir_load_en, reg_write_en, alu_en, jump_en, halt, fault;
  logic [3:0]        alu_opcode;
  logic [CNT_W-1:0]  perf_instr;

  seq_control_unit #(.OPC_W(OPC_W), .FLAG_W(FLAG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .status_reg(status_reg), .mem_ack(mem_ack),
    .resume(resume), .mem_req(mem_req), .mem_we(mem_we), .ir_load_en(ir_load_en),
    .reg_write_en(reg_write_en), .alu_en(alu_en), .alu_opcode(alu_opcode), .jump_en(jump_en),
    .halt(halt), .fault(fault), .perf_instr(perf_instr)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [CNT_W-1:0] retired = '0;

  task check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function logic [11:0] outs_now();
    return {mem_req, mem_we, ir_load_en, reg_write_en, alu_en, alu_opcode, jump_en, halt, fault};
  endfunction

  function logic [11:0] pack(input bit req, we, irl, rwe, alu, input logic [3:0] aop,
                             input bit jmp, hlt, flt);
    return {req, we, irl, rwe, alu, aop, jmp, hlt, flt};
  endfunction

  function logic [CNT_W-1:0] perf_exp();
`ifdef PERF_CNT_EN
    return retired;
`else
    return '0;
`endif
  endfunction

  function bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One cycle: drive inputs just after the edge, check before the next edge, count retirement at that edge.
  task apply_stimulus(input string tag, input bit ack, input bit rsm, input logic [11:0] exp, input bit retire);
    mem_ack = ack;
    resume  = rsm;
    #1;
    check_output(tag, 32'(outs_now()), 32'(exp));
    check_output({tag, "_perf"}, 32'(perf_instr), 32'(perf_exp()));
    @(posedge clk); #1;
    if (retire) retired++;
  endtask

  task do_reset();
    reset   = 1'b0;
    mem_ack = 1'b0;
    resume  = 1'b0;
    retired = '0;
    #1;
    check_output("rst_assert", 32'(outs_now()), 32'd0);
    check_output("rst_perf", 32'(perf_instr), 32'd0);
    @(posedge clk); #1;
    check_output("rst_hold", 32'(outs_now()), 32'd0);
    reset = 1'b1;
    #1;
    check_output("rst_idle", 32'(outs_now()), 32'd0);
    @(posedge clk); #1;
  endtask

  task fault_tail(input string tag);
    for (int i = 0; i < 4; i++) apply_stimulus(tag, rnd(), 1'b1, pack(0,0,0,0,0,4'h0,0,1,1), 1'b0);
    do_reset();
  endtask

  // fd/md: idle cycles before ack; >= MEM_TIMEOUT never acks; md < 0 resets mid-MEM. For HLT, md is the hold length.
  task run_instr(input logic [3:0] opc, input int fd, input int md, input logic [3:0] st);
    bit alu, jmp, to_mem, to_wb;
    opcode     = opc;
    status_reg = st;
    if (fd >= MEM_TIMEOUT) begin
      for (int i = 0; i < MEM_TIMEOUT; i++) apply_stimulus("fetch_wait", 1'b0, rnd(), pack(1,0,0,0,0,4'h0,0,0,0), 1'b0);
      fault_tail("fetch_timeout");
      return;
    end
    for (int i = 0; i <= fd; i++) apply_stimulus("fetch", i == fd, rnd(), pack(1,0,i == fd,0,0,4'h0,0,0,0), 1'b0);
    apply_stimulus("decode", rnd(), rnd(), 12'd0, 1'b0);
    if (opc == 4'hE) begin
      fault_tail("illegal");
      return;
    end
    if (opc == 4'hF) begin
      for (int i = 0; i < md; i++) apply_stimulus("halt", rnd(), 1'b0, pack(0,0,0,0,0,4'h0,0,1,0), 1'b0);
      apply_stimulus("halt_resume", rnd(), 1'b1, pack(0,0,0,0,0,4'h0,0,1,0), 1'b0);
      return;
    end
    alu    = (opc inside {4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hD});
    jmp    = (opc == 4'h8) || (opc == 4'h9 && st[0]) || (opc == 4'hA && st[1]) || (opc == 4'hB && st[2]);
    to_mem = (opc == 4'h1) || (opc == 4'h2);
    to_wb  = (alu && opc != 4'hC) || (opc == 4'h1);
    apply_stimulus("exec", rnd(), rnd(), pack(0,0,0,0,alu, alu ? opc : 4'h0, jmp,0,0), !to_mem && !to_wb);
    if (to_mem) begin
      if (md < 0) begin
        apply_stimulus("mem_pre_reset", 1'b0, 1'b0, pack(1,opc == 4'h2,0,0,0,4'h0,0,0,0), 1'b0);
        do_reset();
        return;
      end
      if (md >= MEM_TIMEOUT) begin
        for (int i = 0; i < MEM_TIMEOUT; i++) apply_stimulus("mem_wait", 1'b0, rnd(), pack(1,opc == 4'h2,0,0,0,4'h0,0,0,0), 1'b0);
        fault_tail("mem_timeout");
        return;
      end
      for (int i = 0; i <= md; i++)
        apply_stimulus("mem", i == md, rnd(), pack(1,opc == 4'h2,0,0,0,4'h0,0,0,0), (i == md) && (opc == 4'h2));
    end
    if (to_wb) apply_stimulus("wb", rnd(), rnd(), pack(0,0,0,1,0,4'h0,0,0,0), 1'b1);
  endtask

  initial begin
    reset = 1'b0; opcode = '0; status_reg = '0; mem_ack = 1'b0; resume = 1'b0;
    #1;
    check_output("por_outputs", 32'(outs_now()), 32'd0);
    check_output("por_perf", 32'(perf_instr), 32'd0);
    #11 reset = 1'b1;
    #1;
    check_output("por_idle", 32'(outs_now()), 32'd0);
    @(posedge clk); #1;

    run_instr(4'h3, 0, 0, 4'h0);
    run_instr(4'h1, 0, 3, 4'h0);
    run_instr(4'h9, 0, 0, 4'b0001);
    run_instr(4'h9, 0, 0, 4'b0000);
    run_instr(4'h8, 1, 0, 4'b0000);
    run_instr(4'hA, 0, 0, 4'b0010);
    run_instr(4'hB, 0, 0, 4'b0100);
    run_instr(4'hC, 0, 0, 4'h0);
    run_instr(4'hF, 0, 20, 4'h0);
    run_instr(4'h3, MEM_TIMEOUT - 1, 0, 4'h0);
    run_instr(4'h2, 0, MEM_TIMEOUT - 1, 4'h0);

    for (int n = 0; n < 80; n++) begin
      logic [3:0] opc;
      int fd, md;
      opc = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 13));
      fd  = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT - 1 : $urandom_range(0, 3);
      md  = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT - 1 : $urandom_range(0, 3);
      if (opc == 4'hF) md = $urandom_range(0, 5);
      run_instr(opc, fd, md, 4'($urandom));
    end

    run_instr(4'hE, 0, 0, 4'h0);
    run_instr(4'h2, 0, -1, 4'h0);
    run_instr(4'h0, MEM_TIMEOUT, 0, 4'h0);
    run_instr(4'h1, 0, MEM_TIMEOUT, 4'h0);
    run_instr(4'h3, 0, 0, 4'h0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
- Parametrised multi-cycle successor to the 4-bit CPU control unit.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK phases.
- Drives IR load, register write, ALU enable/opcode, jump and halt strobes.
- Adds a memory req/ack handshake with timeout, conditional branches on status flags, a resumable HALT, a sticky FAULT, and an optional retired-instruction counter.

Parameters:
- OPC_W, 4: opcode width, must be >= 4. Bits above bit 3 must be zero, otherwise the opcode is illegal.
- FLAG_W, 4: status_reg width, must be >= 3. Bit 0 = Z, bit 1 = C, bit 2 = N.
- MEM_TIMEOUT, 15: consecutive no-ack cycles in FETCH or MEM before entering FAULT. 0 disables the timeout.
- CNT_W, 16: width of perf_instr.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPC_W  instruction opcode from IR; valid in DECODE.
- status_reg  in  FLAG_W  ALU flags, sampled in EXEC.
- mem_ack  in  1  memory completion, single-cycle pulse.
- resume  in  1  leave HALT.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write qualifier for mem_req (STORE).
- ir_load_en  out  1  IR capture strobe.
- reg_write_en  out  1  register-file write strobe.
- alu_en  out  1  ALU enable.
- alu_opcode  out  4  ALU operation code.
- jump_en  out  1  PC load from target.
- halt  out  1  core halted.
- fault  out  1  sticky illegal-opcode / timeout flag.
- perf_instr  out  CNT_W  retired-instruction count.

Behaviour:
- Opcode map:
  - 0000 NOP
  - 0001 LOAD
  - 0010 STORE
  - 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 0111 XOR, 1101 NOT
  - 1100 CMP (ALU, no write)
  - 1000 JMP, 1001 JZ, 1010 JC, 1011 JN
  - 1111 HLT
  - 1110 illegal
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- Output decoding:
  - All outputs decode from the state register, except ir_load_en = (FETCH && mem_ack).
  - An opcode register op_q is captured in DECODE.
- Reset:
  - Async assert forces IDLE, op_q = 0, wait counter = 0, perf_instr = 0.
  - All outputs are 0 while reset is asserted, including alu_opcode = 0.
  - IDLE → FETCH on the first clock after release.
  - Reset mid-operation (any state) aborts immediately with no further strobes.
- FETCH:
  - mem_req = 1, mem_we = 0.
  - On mem_ack: ir_load_en = 1 that cycle, then → DECODE.
- DECODE (1 cycle):
  - Capture op_q.
  - HLT → HALT; illegal → FAULT; else → EXEC.
- EXEC (1 cycle):
  - ALU ops and CMP: alu_en = 1, alu_opcode = op_q.
  - JMP: jump_en = 1.
  - JZ/JC/JN: jump_en = status_reg[0]/[1]/[2], sampled this cycle.
  - Next state:
    - ALU ops except CMP → WB.
    - LOAD, STORE → MEM.
    - NOP, CMP, jumps → FETCH.
- MEM:
  - mem_req = 1; mem_we = 1 for STORE only.
  - On mem_ack: LOAD → WB; STORE → FETCH.
- WB (1 cycle): reg_write_en = 1, → FETCH.
- Cycle latency, ack same cycle as req:
  - NOP / CMP / jump: 3 cycles.
  - ALU op: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Timeout:
  - Wait counter clears on entry to FETCH or MEM and increments each cycle without mem_ack.
  - Reaching MEM_TIMEOUT → FAULT.
  - mem_ack on the same cycle as the limit wins; no fault.
- HALT:
  - halt = 1, all other strobes 0.
  - resume → FETCH next cycle.
  - resume is ignored in all other states.
- FAULT:
  - fault = 1, halt = 1.
  - Exit only by reset; resume is ignored.
- mem_ack outside FETCH/MEM is ignored.
- Retirement: an instruction retires on the cycle it leaves EXEC → FETCH, MEM → FETCH, or WB → FETCH. HLT does not retire.

Optional Feature:
- PERF_CNT_EN defined:
  - perf_instr increments by 1 per retired instruction.
  - Wraps from all-ones to 0.
  - Reset clears it.
- Undefined: perf_instr is tied to 0 and no counter register is synthesised.

Test Plan:
- ADD: reset low 12 ns then high; opcode = 0011; mem_ack pulsed in the first FETCH cycle → ir_load_en 1 cycle, DECODE, alu_en = 1 with alu_opcode = 0011 in EXEC, reg_write_en = 1 in WB, FETCH 4 cycles after the previous FETCH entry; perf_instr = 1 (PERF_CNT_EN).
- LOAD with 3-cycle ack delay in MEM: opcode = 0001 → mem_req held 4 cycles with mem_we = 0, WB after ack, reg_write_en 1 cycle; mem_ack outside FETCH/MEM does not affect state or strobes.
- Conditional branch: JZ with status_reg = 0001 → jump_en = 1 in EXEC; status_reg = 0000 → jump_en = 0; JMP always gives jump_en = 1.
- HLT then illegal opcode:
  - opcode = 1111 → halt = 1 and stays 1 for 20 cycles; resume pulse → FETCH next cycle, halt = 0.
  - opcode = 1110 → fault = 1 and halt = 1; resume is ignored; only reset clears fault.
- Timeout (MEM_TIMEOUT = 15): no mem_ack in FETCH for 15 cycles → FAULT; mem_ack arriving on cycle 15 → no fault.
- Reset mid-MEM during a STORE: mem_req = 1, mem_we = 1; assert reset → all outputs 0 immediately; after release IDLE → FETCH; perf_instr = 0.
